// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: LED register, synchronized switch port and an optional compare timer.
// The timer, CMP/CTRL/STATUS registers and the match flag exist only when IO_BRIDGE_TIMER_EN is defined.
module io_bridge #(
    parameter int data_width = 16,
    parameter int io_width   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            mem_cmd,
    input  logic [8:0]            mem_addr,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] mdata,
    input  logic [io_width-1:0]   sw,
    output logic [io_width-1:0]   led,
    output logic                  timer_flag
);

    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b11;

    localparam logic [7:0] ADDR_SW     = 8'h00;
    localparam logic [7:0] ADDR_LED    = 8'h01;
    localparam logic [7:0] ADDR_COUNT  = 8'h02;
    localparam logic [7:0] ADDR_CMP    = 8'h03;
    localparam logic [7:0] ADDR_CTRL   = 8'h04;
    localparam logic [7:0] ADDR_STATUS = 8'h05;

    logic                  hit;
    logic                  rd;
    logic                  wr;
    logic [7:0]            offs;
    logic [data_width-1:0] rdata;

    logic [io_width-1:0]   sw_meta_q;
    logic [io_width-1:0]   sw_sync_q;
    logic [io_width-1:0]   led_q;
    logic [io_width-1:0]   led_d;

    assign hit  = mem_addr[8];
    assign offs = mem_addr[7:0];
    assign rd   = hit && (mem_cmd == CMD_READ);
    assign wr   = hit && (mem_cmd == CMD_WRITE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            led_q     <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            led_q     <= led_d;
        end
    end

    always_comb begin
        led_d = led_q;
        if (wr && (offs == ADDR_LED)) begin
            led_d = din[io_width-1:0];
        end
    end

    assign led = led_q;

`ifdef IO_BRIDGE_TIMER_EN
    logic [data_width-1:0] count_q;
    logic [data_width-1:0] count_d;
    logic [data_width-1:0] cmp_q;
    logic [data_width-1:0] cmp_d;
    logic [1:0]            ctrl_q;
    logic [1:0]            ctrl_d;
    logic                  flag_q;
    logic                  flag_d;
    logic                  en;
    logic                  ar;
    logic                  match;

    assign en    = ctrl_q[0];
    assign ar    = ctrl_q[1];
    assign match = en && (count_q == cmp_q);

    always_comb begin
        count_d = count_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        flag_d  = flag_q;

        if (wr && (offs == ADDR_COUNT)) begin
            count_d = din;
        end else if (match && ar) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end

        if (wr && (offs == ADDR_CMP)) begin
            cmp_d = din;
        end
        if (wr && (offs == ADDR_CTRL)) begin
            ctrl_d = din[1:0];
        end

        // A match on the same edge as a clear keeps the flag set.
        if (match) begin
            flag_d = 1'b1;
        end else if (wr && (offs == ADDR_STATUS) && din[0]) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            cmp_q   <= '1;
            ctrl_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            flag_q  <= flag_d;
        end
    end

    assign timer_flag = flag_q;
`else
    logic unused_din;
    assign unused_din = ^din[data_width-1:io_width];
    assign timer_flag = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (offs)
            ADDR_SW:     rdata[io_width-1:0] = sw_sync_q;
            ADDR_LED:    rdata[io_width-1:0] = led_q;
`ifdef IO_BRIDGE_TIMER_EN
            ADDR_COUNT:  rdata = count_q;
            ADDR_CMP:    rdata = cmp_q;
            ADDR_CTRL:   rdata[1:0] = ctrl_q;
            ADDR_STATUS: rdata[0] = flag_q;
`endif
            default:     rdata = '0;
        endcase
    end

    // Bus is shared with the RAM, so drive it only while this block is being read.
    assign mdata = rd ? rdata : {data_width{1'bz}};

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: vector table for bus/LED/SW decode plus timer sequences.
// Timer checks follow IO_BRIDGE_TIMER_EN; the released bus is pulled up so Z reads as all ones.
module tb_io_bridge;

    localparam logic [1:0]  C_NONE = 2'b00;
    localparam logic [1:0]  C_WR   = 2'b01;
    localparam logic [1:0]  C_RSV  = 2'b10;
    localparam logic [1:0]  C_RD   = 2'b11;
    localparam logic [15:0] ZBUS   = 16'hFFFF;

    logic        clk;
    logic        reset_n;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] din;
    tri1  [15:0] mdata;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        timer_flag;

    int errors = 0;
    int checks = 0;

    io_bridge #(.data_width(16), .io_width(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .din        (din),
        .mdata      (mdata),
        .sw         (sw),
        .led        (led),
        .timer_flag (timer_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  cmd;
        logic [8:0]  addr;
        logic [15:0] din;
        logic [7:0]  sw;
        logic [15:0] exp_mdata;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd  = c;
        mem_addr = a;
        din      = d;
    endtask

    // One bus cycle ending in a write edge.
    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        drive(C_WR, a, d);
        @(posedge clk);
        #1;
        drive(C_NONE, 9'h000, 16'h0000);
    endtask

    // One read cycle: mdata is compared mid-cycle, then the edge passes.
    task automatic rd_chk(input string name, input logic [8:0] a, input logic [15:0] exp);
        drive(C_RD, a, 16'h0000);
        @(negedge clk);
        check(name, mdata, exp);
        @(posedge clk);
        #1;
        drive(C_NONE, 9'h000, 16'h0000);
    endtask

    initial begin
        vecs[0]  = '{C_NONE, 9'h000, 16'h0000, 8'h00, ZBUS,     8'h00};
        vecs[1]  = '{C_WR,   9'h101, 16'hA5C3, 8'h00, ZBUS,     8'h00};
        vecs[2]  = '{C_RD,   9'h101, 16'h0000, 8'h00, 16'h00C3, 8'hC3};
        vecs[3]  = '{C_WR,   9'h001, 16'h00FF, 8'h5A, ZBUS,     8'hC3};
        vecs[4]  = '{C_RD,   9'h100, 16'h0000, 8'h5A, 16'h0000, 8'hC3};
        vecs[5]  = '{C_RD,   9'h100, 16'h0000, 8'h5A, 16'h005A, 8'hC3};
        vecs[6]  = '{C_RD,   9'h001, 16'h0000, 8'h5A, ZBUS,     8'hC3};
        vecs[7]  = '{C_WR,   9'h101, 16'h0012, 8'h5A, ZBUS,     8'hC3};
        vecs[8]  = '{C_RD,   9'h101, 16'h0000, 8'h81, 16'h0012, 8'h12};
        vecs[9]  = '{C_RD,   9'h100, 16'h0000, 8'h81, 16'h005A, 8'h12};
        vecs[10] = '{C_RD,   9'h100, 16'h0000, 8'h81, 16'h0081, 8'h12};
        vecs[11] = '{C_RSV,  9'h101, 16'h00FF, 8'h81, ZBUS,     8'h12};
        vecs[12] = '{C_RD,   9'h101, 16'h0000, 8'h81, 16'h0012, 8'h12};
        vecs[13] = '{C_RD,   9'h1FF, 16'h0000, 8'h81, 16'h0000, 8'h12};
        vecs[14] = '{C_WR,   9'h1FF, 16'h0000, 8'h81, ZBUS,     8'h12};
        vecs[15] = '{C_RD,   9'h101, 16'h0000, 8'h81, 16'h0012, 8'h12};

        reset_n = 1'b0;
        sw      = 8'h00;
        drive(C_RD, 9'h101, 16'h0000);
        #2;
        check("reset_led", {8'h00, led}, 16'h0000);
        check("reset_mdata_read", mdata, 16'h0000);
        check("reset_flag", {15'h0, timer_flag}, 16'h0000);
        drive(C_NONE, 9'h101, 16'h0000);
        #1;
        check("reset_mdata_idle_z", mdata, ZBUS);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].cmd, vecs[i].addr, vecs[i].din);
            sw = vecs[i].sw;
            @(negedge clk);
            check($sformatf("vec%0d_mdata", i), mdata, vecs[i].exp_mdata);
            check($sformatf("vec%0d_led", i), {8'h00, led}, {8'h00, vecs[i].exp_led});
            check($sformatf("vec%0d_flag", i), {15'h0, timer_flag}, 16'h0000);
            @(posedge clk);
            #1;
        end
        drive(C_NONE, 9'h000, 16'h0000);

`ifdef IO_BRIDGE_TIMER_EN
        rd_chk("cmp_reset", 9'h103, 16'hFFFF);
        wr(9'h103, 16'h0003);
        wr(9'h104, 16'h0003);
        rd_chk("ar_count0", 9'h102, 16'h0000);
        rd_chk("ar_count1", 9'h102, 16'h0001);
        rd_chk("ar_count2", 9'h102, 16'h0002);
        check("ar_flag_before", {15'h0, timer_flag}, 16'h0000);
        rd_chk("ar_count3", 9'h102, 16'h0003);
        check("ar_flag_set", {15'h0, timer_flag}, 16'h0001);
        rd_chk("ar_reload0", 9'h102, 16'h0000);
        wr(9'h105, 16'h0001);
        check("w1c_clear", {15'h0, timer_flag}, 16'h0000);
        rd_chk("ar_count2b", 9'h102, 16'h0002);
        wr(9'h105, 16'h0001);
        check("set_beats_clear", {15'h0, timer_flag}, 16'h0001);
        rd_chk("ar_reload0b", 9'h102, 16'h0000);
        rd_chk("status_read", 9'h105, 16'h0001);
        rd_chk("ctrl_read", 9'h104, 16'h0003);
        wr(9'h104, 16'h0000);
        wr(9'h105, 16'h0001);
        check("flag_cleared", {15'h0, timer_flag}, 16'h0000);
        wr(9'h102, 16'hFFFE);
        wr(9'h103, 16'h0005);
        wr(9'h104, 16'h0001);
        rd_chk("wrap_fffe", 9'h102, 16'hFFFE);
        rd_chk("wrap_ffff", 9'h102, 16'hFFFF);
        rd_chk("wrap_0000", 9'h102, 16'h0000);
        check("wrap_no_flag", {15'h0, timer_flag}, 16'h0000);
        for (int n = 1; n < 5; n++) begin
            rd_chk($sformatf("wrap_count%0d", n), 9'h102, n[15:0]);
        end
        check("flag_before_5", {15'h0, timer_flag}, 16'h0000);
        rd_chk("count5", 9'h102, 16'h0005);
        check("flag_after_5", {15'h0, timer_flag}, 16'h0001);
        rd_chk("no_reload_6", 9'h102, 16'h0006);
`else
        wr(9'h104, 16'h0001);
        rd_chk("noTimer_count", 9'h102, 16'h0000);
        check("noTimer_flag", {15'h0, timer_flag}, 16'h0000);
        wr(9'h102, 16'h1234);
        rd_chk("noTimer_count_wr", 9'h102, 16'h0000);
        wr(9'h103, 16'h0000);
        rd_chk("noTimer_cmp", 9'h103, 16'h0000);
        rd_chk("noTimer_ctrl", 9'h104, 16'h0000);
        rd_chk("noTimer_status", 9'h105, 16'h0000);
        check("noTimer_flag_end", {15'h0, timer_flag}, 16'h0000);
`endif

        // Reset arriving mid-write must not let the write land.
        drive(C_WR, 9'h101, 16'h0077);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        drive(C_NONE, 9'h000, 16'h0000);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_led", {8'h00, led}, 16'h0000);
        rd_chk("abort_led_read", 9'h101, 16'h0000);
        rd_chk("sw_after_reset", 9'h100, 16'h0081);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
